// File: rtl/countdown_timer.sv
// MM:SS down-counting timer with BCD borrow chain, one-second prescaler,
// one-cycle expiry pulse and held done flag.
module countdown_timer #(
  parameter int TickDiv  = 100_000_000,
  parameter int DivWidth = 27
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        start,
  input  logic        stop,
  output logic [15:0] digits,
  output logic        running,
  output logic        done,
  output logic        expired
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam logic [DivWidth-1:0] TickMax = DivWidth'(TickDiv - 1);

  state_t              state;
  logic [DivWidth-1:0] prescaler;
  logic                tick;
  logic [15:0]         dec_value;

  // Saturate each nibble to its legal BCD maximum (sec_tens tops out at 5).
  function automatic logic [15:0] clamp(input logic [15:0] value);
    logic [15:0] result;
    result[15:12] = (value[15:12] > 4'd9) ? 4'd9 : value[15:12];
    result[11:8]  = (value[11:8]  > 4'd9) ? 4'd9 : value[11:8];
    result[7:4]   = (value[7:4]   > 4'd5) ? 4'd5 : value[7:4];
    result[3:0]   = (value[3:0]   > 4'd9) ? 4'd9 : value[3:0];
    return result;
  endfunction

  // Ripple borrow from sec_ones upward; min_tens never wraps because the
  // count is always nonzero while running.
  function automatic logic [15:0] decrement(input logic [15:0] value);
    logic [15:0] result;
    logic        borrow;
    result = value;
    borrow = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (borrow) begin
        if (value[4*k +: 4] == 4'd0) begin
          result[4*k +: 4] = (k == 1) ? 4'd5 : 4'd9;
        end else begin
          result[4*k +: 4] = value[4*k +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    if (borrow) result[15:12] = value[15:12] - 4'd1;
    return result;
  endfunction

  assign tick      = (state == RUN) && (prescaler == TickMax);
  assign dec_value = decrement(digits);
  assign running   = (state == RUN);
  assign done      = (state == DONE);

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      digits    <= 16'h0000;
      prescaler <= '0;
      expired   <= 1'b0;
    end else begin
      expired <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load) begin
            digits    <= clamp(load_value);
            prescaler <= '0;
          end else if (start && !stop) begin
            prescaler <= '0;
            if (digits != 16'h0000) begin
              state <= RUN;
            end else begin
              state   <= DONE;
              expired <= 1'b1;
            end
          end
        end
        RUN: begin
          // Load is ignored while running; the prescaler advances on the
          // stop edge too, so a pause delays the next tick by its length.
          if (tick) begin
            prescaler <= '0;
            if (dec_value == 16'h0000) begin
              digits  <= 16'h0000;
              state   <= DONE;
              expired <= 1'b1;
            end else begin
              digits <= dec_value;
              if (stop) state <= PAUSE;
            end
          end else begin
            prescaler <= prescaler + 1'b1;
            if (stop) state <= PAUSE;
          end
        end
        PAUSE: begin
          if (load) begin
            digits    <= clamp(load_value);
            prescaler <= '0;
            state     <= IDLE;
          end else if (start && !stop) begin
            state <= RUN;
          end
        end
        DONE: begin
          if (load) begin
            digits    <= clamp(load_value);
            prescaler <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: a seconds-based reference model
// compared every cycle, plus directed literal expectations.
module tb_countdown_timer;

  localparam int TickDiv  = 4;
  localparam int DivWidth = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] load_value = 16'h0000;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] digits;
  logic        running;
  logic        done;
  logic        expired;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  countdown_timer #(.TickDiv(TickDiv), .DivWidth(DivWidth)) dut (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .start(start), .stop(stop), .digits(digits), .running(running),
    .done(done), .expired(expired)
  );

  always #5 clk = ~clk;

  // Reference model: total seconds remaining, elapsed cycles in the current
  // second, and a mode number (0 idle, 1 run, 2 pause, 3 done).
  int m_secs  = 0;
  int m_phase = 0;
  int m_mode  = 0;
  bit m_exp   = 1'b0;

  function automatic int load_secs(input logic [15:0] v);
    int mt, mo, st, so;
    mt = (v[15:12] > 9) ? 9 : int'(v[15:12]);
    mo = (v[11:8]  > 9) ? 9 : int'(v[11:8]);
    st = (v[7:4]   > 5) ? 5 : int'(v[7:4]);
    so = (v[3:0]   > 9) ? 9 : int'(v[3:0]);
    return (mt * 10 + mo) * 60 + st * 10 + so;
  endfunction

  function automatic logic [15:0] to_bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_secs <= 0; m_phase <= 0; m_mode <= 0; m_exp <= 1'b0;
    end else begin
      m_exp <= 1'b0;
      if (m_mode == 1) begin
        if (m_phase == TickDiv - 1) begin
          m_phase <= 0;
          m_secs  <= m_secs - 1;
          if (m_secs == 1) begin
            m_mode <= 3; m_exp <= 1'b1;
          end else if (stop) begin
            m_mode <= 2;
          end
        end else begin
          m_phase <= m_phase + 1;
          if (stop) m_mode <= 2;
        end
      end else if (load) begin
        m_secs <= load_secs(load_value); m_phase <= 0; m_mode <= 0;
      end else if (start && !stop && m_mode == 0) begin
        m_phase <= 0;
        if (m_secs != 0) m_mode <= 1;
        else begin m_mode <= 3; m_exp <= 1'b1; end
      end else if (start && !stop && m_mode == 2) begin
        m_mode <= 1;
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_digits",  digits, to_bcd(m_secs));
      check("model_running", 16'(running), 16'(m_mode == 1));
      check("model_done",    16'(done),    16'(m_mode == 3));
      check("model_expired", 16'(expired), 16'(m_exp));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; load_value = v;
    cycles(1);
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cycles(1);
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    cycles(1);
    stop = 1'b0;
  endtask

  initial begin
    cycles(2);
    cmp_en = 1'b1;
    reset = 1'b0;
    check("reset_digits", digits, 16'h0000);
    check("reset_flags", {13'd0, running, done, expired}, 16'h0000);

    // Three-second countdown to expiry.
    do_load(16'h0003);
    check("load_0003", digits, 16'h0003);
    do_start();
    cycles(3);
    check("no_dec_before_tick", digits, 16'h0003);
    cycles(1);
    check("dec_at_4", digits, 16'h0002);
    cycles(4);
    check("dec_at_8", digits, 16'h0001);
    cycles(4);
    check("dec_at_12", digits, 16'h0000);
    check("expiry_flags", {13'd0, running, done, expired}, 16'h0003);
    cycles(1);
    check("expired_one_cycle", 16'(expired), 16'h0000);

    // Full borrow across the three lower digits, then load-in-RUN ignored.
    do_load(16'h1000);
    do_start();
    cycles(4);
    check("borrow_1000", digits, 16'h0959);
    do_load(16'h0003);
    check("load_in_run_ignored", digits, 16'h0959);
    cycles(3);
    check("count_continues", digits, 16'h0958);
    do_stop();
    check("stopped", 16'(running), 16'h0000);

    // Pause mid-second and resume.
    do_load(16'h0005);
    do_start();
    cycles(1);
    do_stop();
    cycles(10);
    check("pause_frozen", digits, 16'h0005);
    check("pause_not_running", 16'(running), 16'h0000);
    do_start();
    check("resumed", 16'(running), 16'h0001);
    cycles(1);
    check("resume_no_dec_yet", digits, 16'h0005);
    cycles(1);
    check("resume_dec", digits, 16'h0004);
    do_stop();

    // Clamping, zero start, repeated start in DONE.
    do_load(16'hFFFF);
    check("clamp_ffff", digits, 16'h9959);
    do_load(16'h5C3E);
    check("clamp_5c3e", digits, 16'h5939);
    do_load(16'h0000);
    do_start();
    check("zero_start_done", {13'd0, running, done, expired}, 16'h0003);
    cycles(1);
    do_start();
    cycles(2);
    check("no_second_pulse", 16'(expired), 16'h0000);
    do_load(16'h0002);
    check("load_in_done", {13'd0, running, done, expired}, 16'h0000);

    // start and stop together in IDLE: stop wins.
    start = 1'b1; stop = 1'b1;
    cycles(1);
    start = 1'b0; stop = 1'b0;
    check("start_stop_idle", 16'(running), 16'h0000);

    // Reset mid-count with the prescaler at 2.
    do_load(16'h0042);
    do_start();
    cycles(2);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    check("midreset_digits", digits, 16'h0000);
    check("midreset_flags", {13'd0, running, done, expired}, 16'h0000);
    do_start();
    check("start_after_reset", {13'd0, running, done, expired}, 16'h0003);
    cycles(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Down-counting MM:SS timer for the stopwatch design, the counterpart of the cascaded up-count digit chain. Loads a packed BCD start value, counts down one second per internal prescaler tick through a borrow chain (ones 9→0, seconds-tens 5→0), and raises a one-cycle expiry pulse and a held done flag at 00:00. It sits beside the stopwatch core and drives the same four-digit display path.

## Interface
- TickDiv, 100_000_000, clk cycles per one-second tick (≥2)
- DivWidth, 27, prescaler width (2^DivWidth ≥ TickDiv)
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- load  input  1  load load_value (one-cycle strobe)
- load_value  input  16  BCD {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each
- start  input  1  begin or resume counting (strobe)
- stop  input  1  pause counting (strobe)
- digits  output  16  current count, same packing as load_value
- running  output  1  high in RUN
- done  output  1  high in DONE
- expired  output  1  one-cycle pulse on reaching 00:00

## Operation
- States: IDLE, RUN, PAUSE, DONE. Reset: state IDLE, digits 16'h0000, prescaler 0, running/done/expired 0.
- Priority per cycle: reset > load > stop > start.
- load (IDLE/PAUSE/DONE): digits ← clamped load_value; prescaler ← 0; state → IDLE. load in RUN ignored.
- Clamp per nibble: sec_ones, min_ones, min_tens >9 → 9; sec_tens >5 → 5. Max value 99:59.
- start in IDLE: count ≠ 0 → RUN, prescaler ← 0; count = 0 → DONE with expired pulse.
- start in PAUSE → RUN, prescaler keeps its value (resume mid-second).
- start in RUN or DONE: no effect (no second expired pulse).
- stop in RUN → PAUSE; stop elsewhere ignored. start and stop together: stop wins.
- Prescaler counts 0..TickDiv-1 only in RUN; tick = RUN & (prescaler == TickDiv-1); prescaler wraps to 0 on tick.
- Borrow chain on tick: digit k decrements when borrow_in_k = 1 (borrow_in_0 = tick); borrow_out_k = (digit_k == 0) & borrow_in_k; a borrowing digit reloads its max (9, or 5 for sec_tens). min_tens only decrements, never wraps (count is nonzero in RUN).
- Example: 10:00 on tick → 09:59; 00:10 → 00:09.
- Tick taking count from 00:01 to 00:00: same edge digits ← 0000, state → DONE.
- DONE holds digits 0000 and done = 1 until load (→ IDLE) or reset.

## Timing
- All outputs registered; running/done reflect state register directly.
- expired high exactly one cycle, the cycle state first reads DONE (either path).
- Load → digits visible the cycle after the load edge.
- From start in IDLE, first decrement at the TickDiv-th rising edge after the start edge; subsequent decrements every TickDiv cycles.
- Pause of N cycles delays the next decrement by exactly N cycles.
- Synchronous reset in any state, including mid-tick, returns to reset values on that edge; no pending tick survives.
- No combinational path from inputs to outputs.

## Test plan
- TickDiv=4. Reset, load 16'h0003, start → digits 0002, 0001, 0000 at 4, 8, 12 cycles after start; done rises and expired pulses once on the 12th edge; running falls same edge.
- Load 16'h1000, start, run one tick → digits 16'h0959; verify full borrow across all three lower digits.
- Load 16'h0005, start, stop after 2 cycles, wait 10 cycles, start → next decrement (0004) 2 cycles after resume; digits frozen and running=0 during pause.
- Load 16'hFFFF → digits 16'h9959; load 16'h0000 then start → DONE next edge, one expired pulse; repeated start in DONE → no further pulse.
- start+stop same cycle in IDLE → stays IDLE; load while RUN → ignored, count continues; load in DONE → IDLE, done=0.
- Assert reset mid-count (digits 0042, prescaler 2) → next edge digits 0000, IDLE, all outputs 0; start afterward → immediate DONE.
